// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bundle between the sequencer and its memory/register-file environment
// master: sequencer side, drives the fetch request, PC, register-file selects and strobes
// slave : environment side, drives start, instruction-memory data/ack and read-port-1 data
interface control_sequencer_if;
    logic       start;
    logic [7:0] mem_data;
    logic       mem_ack;
    logic [7:0] output1;
    logic       mem_req;
    logic [7:0] pc_out;
    logic [1:0] r_signal1;
    logic [1:0] r_signal2;
    logic [1:0] write_register_selection;
    logic       write_enable;
    logic [1:0] alu_op;
    logic       imm_select;
    logic [7:0] imm_data;
    logic       not_selection;
    logic       unconditional_br_selection;
    logic       halted;
    modport master (
        input  start, mem_data, mem_ack, output1,
        output mem_req, pc_out, r_signal1, r_signal2, write_register_selection,
               write_enable, alu_op, imm_select, imm_data, not_selection,
               unconditional_br_selection, halted
    );
    modport slave (
        output start, mem_data, mem_ack, output1,
        input  mem_req, pc_out, r_signal1, r_signal2, write_register_selection,
               write_enable, alu_op, imm_select, imm_data, not_selection,
               unconditional_br_selection, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller for a 4-register 8-bit datapath
// i_clk : system clock, rising edge
// i_rst : asynchronous active-high clear, forces IDLE and all outputs to zero
// bus   : master side of control_sequencer_if (start, memory handshake, register-file control)
module control_sequencer (
    input  logic                i_clk,
    input  logic                i_rst,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, FETCH_IMM, EXECUTE, WRITEBACK, HALT} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_pc, r_instr, r_imm;
    logic [1:0] w_type, w_rd, w_rs, w_sub;
    logic       w_jmp, w_beqz, w_active;
    assign w_type   = r_instr[7:6];
    assign w_rd     = r_instr[5:4];
    assign w_rs     = r_instr[3:2];
    assign w_sub    = r_instr[1:0];
    assign w_jmp    = w_type == 2'b11 && w_sub == 2'b01;
    assign w_beqz   = w_type == 2'b10;
    // read selects only drive the register file while the instruction is being executed/written
    assign w_active = r_state == EXECUTE || r_state == WRITEBACK;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc    <= 8'h00;
            r_instr <= 8'h00;
            r_imm   <= 8'h00;
        end else if (r_state == FETCH && bus.mem_ack) begin
            r_instr <= bus.mem_data;
            r_pc    <= r_pc + 8'd1;
        end else if (r_state == FETCH_IMM && bus.mem_ack) begin
            r_imm   <= bus.mem_data;
            r_pc    <= r_pc + 8'd1;
        end else if (r_state == EXECUTE && (w_jmp || (w_beqz && bus.output1 == 8'h00))) begin
            // Output1 carries register [5:4]: the jump target for JMP, the zero test for BEQZ
            r_pc    <= w_jmp ? bus.output1 : r_imm;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = bus.start ? FETCH : IDLE;
            FETCH:     w_next = bus.mem_ack ? DECODE : FETCH;
            DECODE:    w_next = (w_type == 2'b01 || w_beqz)  ? FETCH_IMM :
                                (w_type == 2'b11 && w_sub == 2'b10) ? HALT :
                                (w_type == 2'b11 && w_sub == 2'b11) ? FETCH : EXECUTE;
            FETCH_IMM: w_next = !bus.mem_ack ? FETCH_IMM : w_beqz ? EXECUTE : WRITEBACK;
            EXECUTE:   w_next = (w_beqz || w_jmp) ? FETCH : WRITEBACK;
            WRITEBACK: w_next = FETCH;
            HALT:      w_next = HALT;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req                    = r_state == FETCH || r_state == FETCH_IMM;
        bus.pc_out                     = r_pc;
        bus.r_signal1                  = w_active ? w_rd : 2'b00;
        bus.r_signal2                  = w_active ? w_rs : 2'b00;
        bus.write_enable               = r_state == WRITEBACK;
        bus.write_register_selection   = r_state == WRITEBACK ? w_rd : 2'b00;
        bus.alu_op                     = (w_active && w_type == 2'b00) ? w_sub : 2'b00;
        bus.imm_select                 = r_state == WRITEBACK && w_type == 2'b01;
        bus.imm_data                   = r_imm;
        bus.not_selection              = w_active && w_type == 2'b11 && w_sub == 2'b00;
        bus.unconditional_br_selection = w_active && w_jmp;
        bus.halted                     = r_state == HALT;
    end
endmodule
